// File: rtl/minterm_scanner.sv
// Truth-table scanner: sweeps in_vec over 0..2^N_IN-1 and gathers y_in into a minterm mask.
// Optional golden-mask compare is enabled with `define MINTERM_SCANNER_COMPARE_EN.
module minterm_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      in_vec,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   mask,
  output logic                 match
);
  localparam int NV = 2**N_IN;
  localparam int HW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [N_IN:0]   LAST_VEC = (N_IN+1)'(NV - 1);
  localparam logic [HW-1:0]   LAST_HOLD = HW'(SETTLE);

  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

  state_t          r_state, w_next;
  logic [N_IN:0]   r_vec;
  logic [HW-1:0]   r_hold;
  logic [NV-1:0]   r_mask;
  logic [NV-1:0]   w_mask_nxt;
  logic            w_accept, w_sample, w_last;

  assign in_vec   = r_vec[N_IN-1:0];
  assign mask     = r_mask;
  assign w_accept = (r_state == IDLE) && start;
  assign w_sample = (r_state == SWEEP) && (r_hold == LAST_HOLD);
  assign w_last   = w_sample && (r_vec == LAST_VEC);

  // Mask with the current sample folded in, so the final compare sees the last bit.
  always_comb begin
    w_mask_nxt         = r_mask;
    w_mask_nxt[in_vec] = y_in;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:   if (start) w_next = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (w_last) w_next = FINISH;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec  <= '0;
      r_hold <= '0;
      r_mask <= '0;
    end else if (w_accept) begin
      r_vec  <= '0;
      r_hold <= '0;
      r_mask <= '0;
    end else if (w_sample) begin
      r_mask <= w_mask_nxt;
      r_hold <= '0;
      r_vec  <= w_last ? '0 : r_vec + 1'b1;
    end else if (r_state == SWEEP) begin
      r_hold <= r_hold + 1'b1;
    end
  end

`ifdef MINTERM_SCANNER_COMPARE_EN
  logic [NV-1:0] r_exp;
  logic          r_match;

  // Result is latched on the final sample so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp   <= '0;
      r_match <= 1'b0;
    end else if (w_accept) begin
      r_exp   <= expected;
      r_match <= 1'b0;
    end else if (w_last) begin
      r_match <= (w_mask_nxt == r_exp);
    end
  end

  assign match = r_match;
`else
  assign match = 1'b0 & (^expected);
`endif

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed-vector bench for minterm_scanner: one instance at SETTLE=0, one at SETTLE=2.
module tb_minterm_scanner;
  logic       clk = 1'b0;
  logic       rst, start0, start1;
  logic [7:0] exp0, exp1;
  logic [2:0] vec0, vec1;
  logic       y0, y1, busy0, busy1, done0, done1, match0, match1;
  logic [7:0] mask0, mask1;
  logic [7:0] fn79 = 8'h79;

  int nvec = 0;
  int nerr = 0;
  int cyc;
  int ndone, dcyc;

`ifdef MINTERM_SCANNER_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  always #5 clk = ~clk;

  assign y0 = fn79[vec0];
  assign y1 = vec1[0];

  minterm_scanner #(.N_IN(3), .SETTLE(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .expected(exp0), .in_vec(vec0),
    .y_in(y0), .busy(busy0), .done(done0), .mask(mask0), .match(match0));

  minterm_scanner #(.N_IN(3), .SETTLE(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1), .in_vec(vec1),
    .y_in(y1), .busy(busy1), .done(done1), .mask(mask1), .match(match1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive start for one edge (edge 0); returns in cycle 1 at a negedge.
  task automatic go0(input logic [7:0] e);
    exp0 = e; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0; cyc = 1;
  endtask

  task automatic tick;
    @(negedge clk); cyc++;
  endtask

  // Run u0 from cycle 1 through cycle 12, checking the sweep and the done cycle.
  task automatic sweep0(input logic [7:0] wmask, input logic wmatch);
    ndone = 0; dcyc = 0;
    while (cyc <= 12) begin
      if (cyc >= 1 && cyc <= 8) begin
        if (vec0 != 3'(cyc - 1) || !busy0) chk("sweep_vec", {28'd0, busy0, vec0}, {28'd1, 3'(cyc - 1)});
      end
      if (done0) begin
        ndone++; dcyc = cyc;
        chk("done_busy", busy0, 0);
        chk("done_mask", mask0, wmask);
        chk("done_match", match0, wmatch);
      end
      tick();
    end
    chk("done_count", ndone, 1);
    chk("done_cycle", dcyc, 9);
  endtask

  initial begin
    rst = 1'b1; start0 = 0; start1 = 0; exp0 = 0; exp1 = 0; cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vec", vec0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_mask", mask0, 0);
    chk("rst_match", match0, 0);
    rst = 1'b0;
    tick();

    // Basic sweep, golden mask matches
    go0(8'h79);
    chk("c1_vec", vec0, 0);
    chk("c1_busy", busy0, 1);
    sweep0(8'h79, CMP);
    chk("idle_hold_mask", mask0, 8'h79);
    chk("idle_hold_match", match0, CMP);
    chk("idle_vec", vec0, 0);

    // Golden mask differs
    go0(8'h7A);
    sweep0(8'h79, 1'b0);

    // SETTLE=2 on u1: vector k from cycle 1+3k, done in cycle 25
    exp1 = 8'hAA; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start1 = 1'b0; cyc = 1;
    ndone = 0; dcyc = 0;
    while (cyc <= 30) begin
      if (cyc == 1)  chk("s2_vec_c1", vec1, 0);
      if (cyc == 3)  chk("s2_vec_c3", vec1, 0);
      if (cyc == 4)  chk("s2_vec_c4", vec1, 1);
      if (cyc == 24) chk("s2_vec_c24", vec1, 7);
      if (done1) begin
        ndone++; dcyc = cyc;
        chk("s2_mask", mask1, 8'hAA);
        chk("s2_match", match1, CMP);
      end
      tick();
    end
    chk("s2_done_count", ndone, 1);
    chk("s2_done_cycle", dcyc, 25);

    // Reset mid-sweep in cycle 4
    go0(8'h79);
    while (cyc < 4) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", busy0, 0);
    chk("abort_mask", mask0, 0);
    chk("abort_vec", vec0, 0);
    chk("abort_done", done0, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      if (done0) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    go0(8'h79);
    sweep0(8'h79, CMP);

    // Start pulses during a running sweep are ignored
    go0(8'h79);
    ndone = 0; dcyc = 0;
    while (cyc <= 20) begin
      start0 = (cyc == 3 || cyc == 8);
      if (done0) begin ndone++; dcyc = cyc; end
      tick();
    end
    start0 = 1'b0;
    chk("ign_done_count", ndone, 1);
    chk("ign_done_cycle", dcyc, 9);
    chk("ign_idle_busy", busy0, 0);

    // Start held high for 30 edges: back-to-back sweeps
    exp0 = 8'h79; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); cyc = 1;
    ndone = 0;
    while (cyc <= 35) begin
      if (cyc == 29) start0 = 1'b0;
      if (cyc == 11) chk("hold_mask_clr", mask0, 0);
      if (cyc == 10) chk("hold_idle_busy", busy0, 0);
      if (done0) begin
        ndone++;
        chk("hold_done_cycle", cyc, 10 * ndone - 1);
        chk("hold_mask", mask0, 8'h79);
      end
      tick();
    end
    chk("hold_done_count", ndone, 3);
    chk("hold_final_busy", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/minterm_scanner.md
# minterm_scanner

Sequential truth-table scanner that sits around a combinational N-input minterm function. It drives every input vector 0..2^N−1 into the function in ascending order and samples the function's single-bit output for each vector. The samples are assembled into a 2^N-bit minterm mask, with bit k = f(k). The block is used to characterise and self-check the minterm logic. It feeds the function's input bus and consumes its output.

## Interface
Parameters:
- N_IN, 3, number of function inputs; 2^N_IN vectors are swept; legal range 1..6.
- SETTLE, 0, extra hold cycles per vector before sampling; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE.
- expected  input  2^N_IN  golden mask; captured on start acceptance.
- in_vec  output  N_IN  vector driven to the minterm function, MSB = input a.
- y_in  input  1  minterm function output, combinational from in_vec.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the mask is complete.
- mask  output  2^N_IN  assembled minterm mask; bit k = sampled y_in for in_vec = k.
- match  output  1  mask == captured expected; valid from done.

## Operation
- FSM states: IDLE, SWEEP, FINISH.
- IDLE: in_vec = 0, busy = 0.
  - start = 1 → SWEEP.
  - On that same edge: mask cleared to 0, expected captured, match cleared, hold counter = 0, in_vec = 0.
- SWEEP: busy = 1.
  - Each vector is held SETTLE+1 cycles.
  - In the last hold cycle, y_in is written into mask[in_vec].
  - in_vec then increments and the hold counter resets.
  - When vector 2^N_IN−1 is sampled → FINISH, and in_vec returns to 0.
- FINISH (one cycle): done = 1, busy = 0, match = (mask == captured expected) if compare is compiled in. Then → IDLE.
- mask and match hold their values in IDLE until the next accepted start.
- start while busy or in FINISH: ignored; no queuing.
- start held high continuously: a new sweep begins in the IDLE cycle following FINISH, i.e. back-to-back sweeps with one IDLE cycle between them.
- in_vec never exceeds 2^N_IN−1 and wraps only via the return to 0 on leaving SWEEP.
- The hold counter is ceil(log2(SETTLE+1)) bits wide (minimum 1). The vector counter is N_IN+1 bits internally, so terminal detection has no overflow.

## Timing
- Reset values: in_vec = 0, busy = 0, done = 0, mask = 0, match = 0, FSM = IDLE, counters = 0.
- rst asserted mid-sweep: the sweep is aborted on that edge, all outputs take their reset values, and no done is issued.
- Reset has priority over start.
- With start accepted at edge 0:
  - vector k is driven from cycle 1 + k·(SETTLE+1);
  - its sample is taken at the end of cycle (k+1)·(SETTLE+1);
  - done is high in cycle 2^N_IN·(SETTLE+1) + 1.
  - For defaults (N_IN = 3, SETTLE = 0): done is high in cycle 9, and the total latency from start to done is 9 cycles.
- mask bits update one at a time during SWEEP. mask is only guaranteed complete when done = 1.
- y_in must be stable by the sample edge. The block adds no input register on y_in.

## Configuration
- MINTERM_SCANNER_COMPARE_EN defined:
  - expected is captured on start acceptance;
  - match is registered in FINISH as mask == captured expected and held until the next start.
- MINTERM_SCANNER_COMPARE_EN undefined:
  - the expected capture register and the comparator are removed;
  - match is tied to 0;
  - the expected port remains but is ignored.

## Test plan
- Reset, then drive y_in from minterms (0,3,4,5,6), start pulse with expected = 8'h79, N_IN = 3, SETTLE = 0 → in_vec steps 0..7 in cycles 1..8; done in cycle 9; mask = 8'h79; match = 1.
- Same function with expected = 8'h7A → mask = 8'h79, match = 0 (match tied 0 when the macro is undefined).
- SETTLE = 2, y_in = in_vec[0] → each vector held 3 cycles; done in cycle 25; mask = 8'hAA.
- Assert rst in cycle 4 of a sweep → on that edge busy = 0, mask = 0, in_vec = 0; no done pulse. A following start completes normally with mask = 8'h79.
- Pulse start again in cycles 3 and 8 of a running sweep → both ignored; exactly one done, in cycle 9.
- Hold start high for 30 cycles → sweeps complete with done in cycles 9, 19 and 29; mask is cleared at each restart.
